freq_bucket_meter: RTL
======================

# freq_bucket_meter

Parametrised successor to the fixed 5 ms frequency-bucket LED counter. Counts edges of an asynchronous square-wave input over a configurable gate window and classifies each window's count into one of `NUM_BUCKETS` linearly spaced buckets plus a no-signal bucket. It adds four things the fixed version lacks:

- optional both-edge counting;
- a saturating counter with an overflow flag;
- a gate enable;
- a stability filter that updates the display only after a bucket repeats for `STABLE_WINDOWS` consecutive windows.

It sits between the input pin and the LED bank, and also exports the raw count for other consumers.

## Interface

**Parameters**

- `WINDOW_CYCLES`, default 240000: gate window length in clock cycles; must be ≥ 4.
- `NUM_BUCKETS`, default 10: number of frequency buckets; must be ≥ 1.
- `BUCKET_BASE`, default 1090: exclusive upper count bound of bucket 0.
- `BUCKET_STEP`, default 990: count width of each subsequent bucket.
- `MIN_COUNT`, default 1: counts below this value classify as no-signal.
- `STABLE_WINDOWS`, default 2: consecutive identical classifications required before the outputs update; must be ≥ 1.
- `BOTH_EDGES`, default 0:
  - 0 = count rising edges only;
  - 1 = count rising and falling edges.
- `CNT_W`, default 14: pulse counter width.
- `BW`, default `$clog2(NUM_BUCKETS+1)`: bucket index width.

**Ports**

- `int_osc` in 1: system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `square` in 1: asynchronous input waveform.
- `en` in 1: gate enable.
- `led` out `NUM_BUCKETS+1`: one-hot display.
  - `led[i]` = bucket i.
  - `led[NUM_BUCKETS]` = no signal.
- `bucket` out `BW`: index of the lit LED.
- `count` out `CNT_W`: edge count of the most recently closed window.
- `count_valid` out 1: one-cycle strobe marking a new `count`.
- `overflow` out 1: the window that produced `count` saturated.

## Operation

**Input conditioning**
- `square` passes through a two-flop synchronizer into `sq_s2`, then a delay flop `sq_d`.
- Rising edge = `sq_s2 & ~sq_d`.
- With `BOTH_EDGES=1`, edge = `sq_s2 ^ sq_d`.

**Window timer**
- `timer` counts 0 .. `WINDOW_CYCLES-1`, then wraps to 0.
- The cycle with `timer == WINDOW_CYCLES-1` is the close cycle.

**Pulse counter**
- Increments on each edge and saturates at 2^`CNT_W`-1.
- Any increment attempted at saturation sets the internal `ovf` flag for that window.

**Close cycle**
- `count` <= pulse count plus any edge present this cycle, saturating.
- `overflow` <= `ovf`, including an overflow caused by this cycle's edge.
- The pulse counter and `ovf` clear to 0.
- No edge is lost or double-counted across the window boundary.

**Classification** (combinational on `count`, 32-bit arithmetic)
- `count < MIN_COUNT` → bucket `NUM_BUCKETS` (no signal).
- Otherwise: bucket = the smallest i in 0..`NUM_BUCKETS-2` with `count < BUCKET_BASE + i*BUCKET_STEP`.
- If no such i exists, bucket = `NUM_BUCKETS-1` (clamp).

**Stability filter** (evaluated in the `count_valid` cycle)
- Registers: `pending` (`BW` bits) and `stable_cnt` (saturating at `STABLE_WINDOWS`).
- If the candidate equals `pending`: `stable_cnt` increments.
- Otherwise: `pending` <= candidate and `stable_cnt` <= 1.
- When the updated `stable_cnt` equals `STABLE_WINDOWS`, `bucket` <= `pending` and `led` <= one-hot(`pending`).
- `bucket` and `led` otherwise hold.

**Enable**
- While `en` = 0, the timer, pulse counter and `ovf` are held at 0.
- No close cycle or `count_valid` occurs while `en` = 0.
- `count`, `overflow`, `led`, `bucket` and the filter state hold.
- The synchronizer keeps running, so the first window after `en` rises is a full `WINDOW_CYCLES` long.

**Reset values**
- `led` = one-hot bit `NUM_BUCKETS`; `bucket` = `NUM_BUCKETS`.
- `count` = 0; `count_valid` = 0; `overflow` = 0.
- `pending` = `NUM_BUCKETS`; `stable_cnt` = 0; `timer` = 0; pulse counter = 0.
- Synchronizer flops = 0.

**Reset mid-window**
- The partial count is discarded and no `count_valid` is issued.
- The timer restarts at 0 on the first cycle after reset deasserts.

## Timing

- An input transition sampled by the first sync flop at cycle k produces its edge strobe at cycle k+2. That edge belongs to the window whose timer value it coincides with at k+2.
- The close cycle is T. `count`, `overflow` and `count_valid` are valid at T+1; `count_valid` is high for exactly one cycle.
- `led` and `bucket` update at T+2, only when the filter condition is met.
- With `STABLE_WINDOWS=1`, every window updates the display at T+2.
- After a frequency step, the display changes at T+2 of the `STABLE_WINDOWS`-th complete window at the new rate. A window that straddles the step counts as a window of its own classification.
- `count_valid` period = `WINDOW_CYCLES` cycles while `en` = 1.

## Test plan

All scenarios use bench parameters `WINDOW_CYCLES=1000`, `NUM_BUCKETS=4`, `BUCKET_BASE=10`, `BUCKET_STEP=10`, `MIN_COUNT=1`, `STABLE_WINDOWS=2`, `CNT_W=6`, `BOTH_EDGES=0` unless a scenario states otherwise.

1. **Reset / idle:** assert `reset` 3 cycles, hold `square`=0 for 3 windows → `led`=5'b10000, `bucket`=4, `count`=0, `count_valid` pulses every 1000 cycles.
2. **Stability filter:** square period 40 cycles, started at timer=0 →
   - `count`=25 each window;
   - `led` unchanged after window 1;
   - `led`=5'b00100, `bucket`=2 at T+2 of window 2.
3. **Flicker rejection:** alternate windows at period 200 (`count`=5) and period 66 (`count`=15) → `led` never changes from its prior value.
4. **Saturation:** square period 4 cycles (250 edges per window) → `count`=63, `overflow`=1, `bucket`=3 after 2 windows. Then period 40 → `overflow`=0 in the next `count_valid`.
5. **Both edges:** `BOTH_EDGES=1`, period 40 → `count`=50, `bucket`=3 after 2 windows. Also inject a boundary edge exactly at the close cycle → it is counted once, in the closing window.
6. **Enable and mid-window reset:**
   - Drop `en` at timer=500 for 2000 cycles → no `count_valid` and outputs hold; after `en` rises, the first `count_valid` comes 1001 cycles later.
   - Pulse `reset` at timer=700 → `led`=5'b10000 and the next `count_valid` comes 1001 cycles after reset deasserts.

Source files
------------

// File: rtl/freq_bucket_meter_if.sv
// Result bus of freq_bucket_meter: per-window edge count and the filtered LED display.
// count_valid is a one-cycle strobe with no ready; count/overflow are stable from the strobe
// until the next one, and led/bucket change only on the cycle after a strobe.
interface freq_bucket_meter_if #(
  parameter int NUM_BUCKETS = 10,
  parameter int CNT_W       = 14,
  parameter int BW          = $clog2(NUM_BUCKETS + 1)
);
  logic [NUM_BUCKETS:0] led;
  logic [BW-1:0]        bucket;
  logic [CNT_W-1:0]     count;
  logic                 count_valid;
  logic                 overflow;

  modport master (output led, bucket, count, count_valid, overflow);
  modport slave  (input  led, bucket, count, count_valid, overflow);
endinterface

// File: rtl/freq_bucket_meter.sv
// Gated edge counter for an asynchronous square wave; classifies each window's count into
// linear frequency buckets and only moves the LED display once a bucket repeats.
module freq_bucket_meter #(
  parameter int WINDOW_CYCLES  = 240000,
  parameter int NUM_BUCKETS    = 10,
  parameter int BUCKET_BASE    = 1090,
  parameter int BUCKET_STEP    = 990,
  parameter int MIN_COUNT      = 1,
  parameter int STABLE_WINDOWS = 2,
  parameter bit BOTH_EDGES     = 1'b0,
  parameter int CNT_W          = 14,
  parameter int BW             = $clog2(NUM_BUCKETS + 1)
) (
  input  logic                int_osc,
  input  logic                reset,
  input  logic                square,
  input  logic                en,
  freq_bucket_meter_if.master m_if
);
  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam int SW = $clog2(STABLE_WINDOWS + 1);
  localparam int LW = NUM_BUCKETS + 1;
  localparam logic [TW-1:0] LAST_T   = TW'(WINDOW_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_N = SW'(STABLE_WINDOWS);
  localparam logic [BW-1:0] NO_SIG   = BW'(NUM_BUCKETS);

  logic            r_sq_s1, r_sq_s2, r_sq_d;
  logic            w_edge;
  logic [TW-1:0]   r_timer;
  logic [CNT_W-1:0] r_pulse;
  logic            r_ovf;
  logic            w_close, w_sat, w_ovf_next;
  logic [CNT_W-1:0] w_pulse_next;
  logic [CNT_W-1:0] r_count;
  logic            r_count_valid, r_overflow;
  logic [31:0]     w_count32;
  logic [BW-1:0]   w_cand;
  logic [BW-1:0]   r_pending, r_bucket;
  logic [SW-1:0]   r_stable_cnt, w_stable_next;
  logic [LW-1:0]   r_led;

  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_sq_s1 <= 1'b0;
      r_sq_s2 <= 1'b0;
      r_sq_d  <= 1'b0;
    end else begin
      r_sq_s1 <= square;
      r_sq_s2 <= r_sq_s1;
      r_sq_d  <= r_sq_s2;
    end
  end

  assign w_edge = BOTH_EDGES ? (r_sq_s2 ^ r_sq_d) : (r_sq_s2 & ~r_sq_d);

  // The close cycle's own edge is folded into the closing window, so nothing leaks across.
  assign w_close      = en && (r_timer == LAST_T);
  assign w_sat        = &r_pulse;
  assign w_pulse_next = (w_edge && !w_sat) ? r_pulse + 1'b1 : r_pulse;
  assign w_ovf_next   = r_ovf | (w_edge & w_sat);

  always_ff @(posedge int_osc) begin
    if (reset || !en || w_close) begin
      r_timer <= '0;
      r_pulse <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_timer <= r_timer + 1'b1;
      r_pulse <= w_pulse_next;
      r_ovf   <= w_ovf_next;
    end
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= w_close;
      if (w_close) begin
        r_count    <= w_pulse_next;
        r_overflow <= w_ovf_next;
      end
    end
  end

  assign w_count32 = 32'(r_count);

  // Walk buckets downwards so the smallest matching index wins; fall-through clamps to the top.
  always_comb begin
    w_cand = BW'(NUM_BUCKETS - 1);
    for (int i = NUM_BUCKETS - 2; i >= 0; i--) begin
      if (w_count32 < 32'(BUCKET_BASE + i * BUCKET_STEP)) w_cand = BW'(i);
    end
    if (w_count32 < 32'(MIN_COUNT)) w_cand = NO_SIG;
  end

  always_comb begin
    w_stable_next = SW'(1);
    if (w_cand == r_pending) begin
      w_stable_next = (r_stable_cnt == STABLE_N) ? STABLE_N : r_stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_pending    <= NO_SIG;
      r_stable_cnt <= '0;
      r_bucket     <= NO_SIG;
      r_led        <= LW'(1) << NUM_BUCKETS;
    end else if (r_count_valid) begin
      r_pending    <= w_cand;
      r_stable_cnt <= w_stable_next;
      if (w_stable_next == STABLE_N) begin
        r_bucket <= w_cand;
        r_led    <= LW'(1) << w_cand;
      end
    end
  end

  assign m_if.led         = r_led;
  assign m_if.bucket      = r_bucket;
  assign m_if.count       = r_count;
  assign m_if.count_valid = r_count_valid;
  assign m_if.overflow    = r_overflow;
endmodule
